// File: rtl/verinject_fault_scheduler.sv
// verinject_fault_scheduler
// Cycle-accurate fault-injection scheduler. The testbench queues (cycle, bit)
// entries in strictly increasing cycle order. Each entry drives its bit index
// on verinject__injector_state for exactly the cycle where cycle_count equals
// the entry's cycle. The output is all-ones (idle) on every other cycle.
// Entries that are due while enable is low, or that are already stale, are
// dropped and counted as missed.
module verinject_fault_scheduler #(
  parameter int unsigned TOTAL_BITS = 0,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         sched_valid,
  output logic                         sched_ready,
  input  logic [47:0]                  sched_cycle,
  input  logic [31:0]                  sched_bit,
  output logic                         sched_reject,
  output logic [31:0]                  verinject__injector_state,
  output logic [47:0]                  cycle_count,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [31:0]                  inject_count,
  output logic [15:0]                  missed_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] FULL_LEVEL = PW'(DEPTH);
  localparam logic [31:0]   BIT_LIMIT  = 32'(TOTAL_BITS);
  localparam logic          RANGE_CHK  = (TOTAL_BITS != 0);
  localparam logic [31:0]   IDLE_CODE  = 32'hFFFF_FFFF;

  // state registers
  logic [47:0]   cycle_q, cycle_d;
  logic [31:0]   state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [47:0]   last_cycle_q, last_cycle_d;
  logic          last_valid_q, last_valid_d;
  logic          reject_q, reject_d;
  logic [31:0]   inj_cnt_q, inj_cnt_d;
  logic [15:0]   miss_cnt_q, miss_cnt_d;
  logic [47:0]   cyc_mem_q [DEPTH];
  logic [31:0]   bit_mem_q [DEPTH];

  // decoded control
  logic [47:0] next_cycle_s;
  logic [47:0] head_cycle_s;
  logic [31:0] head_bit_s;
  logic        head_valid_s;
  logic        ready_s;
  logic        push_s;
  logic        bad_s;
  logic        accept_s;
  logic        fire_s;
  logic        miss_s;
  logic        pop_s;

  // Handshake, entry validation and head-of-queue firing decisions.
  always_comb begin
    next_cycle_s = cycle_q + 48'd1;
    head_cycle_s = cyc_mem_q[rd_ptr_q];
    head_bit_s   = bit_mem_q[rd_ptr_q];
    head_valid_s = (count_q != {PW{1'b0}});
    ready_s      = (count_q != FULL_LEVEL);
    push_s       = sched_valid && ready_s;
    bad_s        = (sched_bit == IDLE_CODE)
                || (RANGE_CHK && (sched_bit >= BIT_LIMIT))
                || (last_valid_q && (sched_cycle <= last_cycle_q));
    accept_s     = push_s && !bad_s;
    // The head is compared against the value cycle_count takes at this edge.
    fire_s       = head_valid_s && (head_cycle_s == next_cycle_s) && enable;
    miss_s       = head_valid_s && (((head_cycle_s == next_cycle_s) && !enable)
                                    || (head_cycle_s < next_cycle_s));
    pop_s        = fire_s || miss_s;
  end

  // Next-state values for counters, pointers and the injector output.
  always_comb begin
    cycle_d      = next_cycle_s;
    reject_d     = push_s && bad_s;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    last_cycle_d = last_cycle_q;
    last_valid_d = last_valid_q;
    inj_cnt_d    = inj_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    state_d      = IDLE_CODE;

    if (accept_s) begin
      wr_ptr_d     = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      last_cycle_d = sched_cycle;
      last_valid_d = 1'b1;
    end else begin
      wr_ptr_d     = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (fire_s) begin
      state_d   = head_bit_s;
      inj_cnt_d = inj_cnt_q + 32'd1;
    end else begin
      state_d   = IDLE_CODE;
    end

    if (miss_s && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end else begin
      miss_cnt_d = miss_cnt_q;
    end

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + {{(PW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(PW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Register all scheduler state; reset discards every queued entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q      <= 48'd0;
      state_q      <= IDLE_CODE;
      rd_ptr_q     <= {AW{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      count_q      <= {PW{1'b0}};
      last_cycle_q <= 48'd0;
      last_valid_q <= 1'b0;
      reject_q     <= 1'b0;
      inj_cnt_q    <= 32'd0;
      miss_cnt_q   <= 16'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        cyc_mem_q[i] <= 48'd0;
        bit_mem_q[i] <= 32'd0;
      end
    end else begin
      cycle_q      <= cycle_d;
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_cycle_q <= last_cycle_d;
      last_valid_q <= last_valid_d;
      reject_q     <= reject_d;
      inj_cnt_q    <= inj_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      if (accept_s) begin
        cyc_mem_q[wr_ptr_q] <= sched_cycle;
        bit_mem_q[wr_ptr_q] <= sched_bit;
      end
    end
  end

  assign sched_ready               = ready_s;
  assign sched_reject              = reject_q;
  assign verinject__injector_state = state_q;
  assign cycle_count               = cycle_q;
  assign pending                   = count_q;
  assign inject_count              = inj_cnt_q;
  assign missed_count              = miss_cnt_q;

endmodule

// File: tb/tb_verinject_fault_scheduler.sv
// Self-checking bench for verinject_fault_scheduler (TOTAL_BITS=64, DEPTH=8).
module tb_verinject_fault_scheduler;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sched_valid = 1'b0;
  logic        sched_ready;
  logic [47:0] sched_cycle = 48'd0;
  logic [31:0] sched_bit = 32'd0;
  logic        sched_reject;
  logic [31:0] inj_state;
  logic [47:0] cycle_count;
  logic [3:0]  pending;
  logic [31:0] inject_count;
  logic [15:0] missed_count;

  verinject_fault_scheduler #(.TOTAL_BITS(64), .DEPTH(DEPTH)) dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .enable                    (enable),
    .sched_valid               (sched_valid),
    .sched_ready               (sched_ready),
    .sched_cycle               (sched_cycle),
    .sched_bit                 (sched_bit),
    .sched_reject              (sched_reject),
    .verinject__injector_state (inj_state),
    .cycle_count               (cycle_count),
    .pending                   (pending),
    .inject_count              (inject_count),
    .missed_count              (missed_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] cyc;
    logic [31:0] bitv;
  } exp_t;

  typedef struct {
    logic [47:0] cyc;
    logic [31:0] bitv;
    logic        rej;
    logic        fire;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   errors = 0;
  int   checks = 0;
  logic mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input logic [47:0] t);
    int n;
    n = 0;
    while ((cycle_count != t) && (n < 400)) begin
      @(negedge clock);
      n++;
    end
    if (cycle_count != t) check("wait_timeout", {16'd0, cycle_count}, {16'd0, t});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   {32'd0, inj_state},    64'hFFFF_FFFF);
    check({tag, "_cycle"},   {16'd0, cycle_count},  64'd0);
    check({tag, "_pending"}, {60'd0, pending},      64'd0);
    check({tag, "_ready"},   {63'd0, sched_ready},  64'd1);
    check({tag, "_reject"},  {63'd0, sched_reject}, 64'd0);
    check({tag, "_inj"},     {32'd0, inject_count}, 64'd0);
    check({tag, "_miss"},    {48'd0, missed_count}, 64'd0);
  endtask

  // Scoreboard monitor: the front entry must appear exactly on its cycle, idle otherwise.
  always @(negedge clock) begin
    if (mon_on) begin
      if ((sb.size() > 0) && (sb[0].cyc == cycle_count)) begin
        check("inject_bit", {32'd0, inj_state}, {32'd0, sb[0].bitv});
        void'(sb.pop_front());
      end else begin
        check("idle_state", {32'd0, inj_state}, 64'hFFFF_FFFF);
      end
    end
  end

  initial begin
    int   acc;
    int   exp_pend;
    logic [47:0] tcyc;

    vecs[0] = '{cyc: 48'd10, bitv: 32'd5,          rej: 1'b0, fire: 1'b1};
    vecs[1] = '{cyc: 48'd20, bitv: 32'd3,          rej: 1'b0, fire: 1'b1};
    vecs[2] = '{cyc: 48'd21, bitv: 32'd7,          rej: 1'b0, fire: 1'b1};
    vecs[3] = '{cyc: 48'd22, bitv: 32'd9,          rej: 1'b0, fire: 1'b1};
    vecs[4] = '{cyc: 48'd30, bitv: 32'd1,          rej: 1'b0, fire: 1'b1};
    vecs[5] = '{cyc: 48'd30, bitv: 32'd2,          rej: 1'b1, fire: 1'b0};
    vecs[6] = '{cyc: 48'd35, bitv: 32'd64,         rej: 1'b1, fire: 1'b0};
    vecs[7] = '{cyc: 48'd35, bitv: 32'hFFFF_FFFF,  rej: 1'b1, fire: 1'b0};
    vecs[8] = '{cyc: 48'd35, bitv: 32'd63,         rej: 1'b0, fire: 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clock);
    tcyc = 48'd1;
    check("cycle_after_release", {16'd0, cycle_count}, {16'd0, tcyc});
    mon_on = 1'b1;

    // Table-driven pushes, one per cycle
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      check("ready_before_push", {63'd0, sched_ready}, 64'd1);
      sched_valid = 1'b1;
      sched_cycle = vecs[i].cyc;
      sched_bit   = vecs[i].bitv;
      if (!vecs[i].rej && vecs[i].fire) sb.push_back('{cyc: vecs[i].cyc, bitv: vecs[i].bitv});
      @(negedge clock);
      tcyc = tcyc + 48'd1;
      if (!vecs[i].rej) acc++;
      exp_pend = 0;
      for (int j = 0; j <= i; j++) begin
        if (!vecs[j].rej && (vecs[j].cyc > tcyc)) exp_pend++;
      end
      check("push_reject", {63'd0, sched_reject}, {63'd0, vecs[i].rej});
      check("push_pending", {60'd0, pending}, 64'(exp_pend));
      check("push_cycle", {16'd0, cycle_count}, {16'd0, tcyc});
    end
    sched_valid = 1'b0;

    // Test 1: single injection counted
    wait_cyc(48'd11);
    check("t1_inject_count", {32'd0, inject_count}, 64'd1);

    // Tests 2-4: back-to-back and accepted range-edge entry all fired
    wait_cyc(48'd36);
    check("t4_inject_count", {32'd0, inject_count}, 64'd6);
    check("t4_missed", {48'd0, missed_count}, 64'd0);
    check("t4_pending", {60'd0, pending}, 64'd0);
    check("t4_sb_drained", 64'(sb.size()), 64'd0);

    // Test 5: entry due while enable is low is missed
    sched_valid = 1'b1;
    sched_cycle = 48'd45;
    sched_bit   = 32'd4;
    @(negedge clock);
    sched_valid = 1'b0;
    check("t5_reject", {63'd0, sched_reject}, 64'd0);
    check("t5_pending", {60'd0, pending}, 64'd1);
    wait_cyc(48'd44);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    check("t5_missed", {48'd0, missed_count}, 64'd1);
    check("t5_inject_count", {32'd0, inject_count}, 64'd6);
    check("t5_pending_after", {60'd0, pending}, 64'd0);

    // Minimum lead time: entry for the very next cycle is missed
    sched_valid = 1'b1;
    sched_cycle = 48'd46;
    sched_bit   = 32'd6;
    @(negedge clock);
    sched_valid = 1'b0;
    check("lead_pending", {60'd0, pending}, 64'd1);
    check("lead_reject", {63'd0, sched_reject}, 64'd0);
    @(negedge clock);
    check("lead_missed", {48'd0, missed_count}, 64'd2);
    check("lead_pending_after", {60'd0, pending}, 64'd0);

    // Test 6: fill the FIFO
    for (int i = 0; i < DEPTH; i++) begin
      sched_valid = 1'b1;
      sched_cycle = 48'd100 + 48'(i);
      sched_bit   = 32'(i);
      @(negedge clock);
      check("fill_reject", {63'd0, sched_reject}, 64'd0);
    end
    check("full_ready", {63'd0, sched_ready}, 64'd0);
    check("full_pending", {60'd0, pending}, 64'd8);
    sched_cycle = 48'd200;
    sched_bit   = 32'd1;
    @(negedge clock);
    sched_valid = 1'b0;
    check("full_no_reject", {63'd0, sched_reject}, 64'd0);
    check("full_pending_hold", {60'd0, pending}, 64'd8);

    // Asynchronous reset mid-cycle
    mon_on = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clock);
    reset_n = 1'b1;
    mon_on  = 1'b1;
    wait_cyc(48'd112);
    check("post_rst_inj", {32'd0, inject_count}, 64'd0);
    check("post_rst_miss", {48'd0, missed_count}, 64'd0);
    check("post_rst_pending", {60'd0, pending}, 64'd0);
    mon_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
